// File: rtl/genetico_evaluator.sv
// genetico_evaluator: fitness-evaluation controller for the genetico evolvable circuit.
// Applies a latched chromosome, sweeps all input vectors, double-samples outputs and scores them.
`default_nettype none

module genetico_evaluator #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int N_LE   = 4,
    parameter int CONF_W = 9,
    parameter int SEL_W  = 3,
    parameter int SETTLE = 4,
    parameter int FIT_W  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [N_LE*CONF_W+N_OUT*SEL_W-1:0]   chrom,
    input  logic [N_OUT*(2**N_IN)-1:0]           target,
    output logic [N_LE*CONF_W-1:0]               conf_les,
    output logic [N_OUT*SEL_W-1:0]               conf_outs,
    output logic [N_IN-1:0]                      chrom_in,
    input  logic [N_OUT-1:0]                     chrom_out,
    output logic                                 busy,
    output logic                                 done,
    output logic [FIT_W-1:0]                     fitness,
    output logic                                 perfect,
    output logic [N_IN:0]                        unstable_cnt
);

    localparam int NVEC  = 2**N_IN;
    localparam int TGT_W = N_OUT*NVEC;
    localparam int LES_W = N_LE*CONF_W;
    localparam int OUTS_W = N_OUT*SEL_W;

    localparam logic [FIT_W-1:0] FIT_ONE   = {{(FIT_W-1){1'b0}}, 1'b1};
    localparam logic [FIT_W-1:0] FIT_MAX   = FIT_W'(TGT_W);
    localparam logic [N_IN:0]    UNST_ONE  = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN-1:0]  VEC_ONE   = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN-1:0]  VEC_LAST  = {N_IN{1'b1}};
    localparam logic [7:0]       CNT_INIT  = 8'(SETTLE-1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state;
    logic [TGT_W-1:0]   tgt;
    logic [N_IN-1:0]    vec;
    logic [7:0]         cnt;
    logic [N_OUT-1:0]   s1;
    logic [FIT_W-1:0]   score;
    logic [N_IN:0]      unst;
    logic [FIT_W-1:0]   match_cnt;

    // Matching bits of the first sample against the target row of the current vector
    always_comb begin
        match_cnt = '0;
        for (int o = 0; o < N_OUT; o++) begin
            if (s1[o] == tgt[N_OUT*int'(vec) + o])
                match_cnt = match_cnt + FIT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            tgt          <= '0;
            vec          <= '0;
            cnt          <= '0;
            s1           <= '0;
            score        <= '0;
            unst         <= '0;
            conf_les     <= '0;
            conf_outs    <= '0;
            chrom_in     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fitness      <= '0;
            perfect      <= 1'b0;
            unstable_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            conf_les  <= chrom[LES_W-1:0];
                            conf_outs <= chrom[LES_W+OUTS_W-1:LES_W];
                            tgt       <= target;
                            vec       <= '0;
                            chrom_in  <= '0;
                            score     <= '0;
                            unst      <= '0;
                            cnt       <= CNT_INIT;
                            busy      <= 1'b1;
                            state     <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt == 8'd0) begin
                            s1    <= chrom_out;
                            state <= ST_CONFIRM;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    ST_CONFIRM: begin
                        // An oscillating output forfeits the whole vector
                        if (chrom_out == s1)
                            score <= score + match_cnt;
                        else
                            unst <= unst + UNST_ONE;
                        if (vec == VEC_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            vec      <= vec + VEC_ONE;
                            chrom_in <= vec + VEC_ONE;
                            cnt      <= CNT_INIT;
                            state    <= ST_SETTLE;
                        end
                    end
                    ST_DONE: begin
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        fitness      <= score;
                        perfect      <= (score == FIT_MAX);
                        unstable_cnt <= unst;
                        state        <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_genetico_evaluator.sv
// tb_genetico_evaluator: directed self-checking bench for genetico_evaluator.
// A behavioural circuit stub routes chrom_in bits to outputs via conf_outs, optionally oscillating out0.
`default_nettype none

module tb_genetico_evaluator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic        abort = 1'b0;
    logic [41:0] chrom = '0;
    logic [7:0]  target = '0;
    logic        osc_mode = 1'b0;
    logic        tog = 1'b0;

    logic [35:0] conf_les, conf_les1;
    logic [5:0]  conf_outs, conf_outs1;
    logic [1:0]  chrom_in, chrom_in1;
    logic [1:0]  chrom_out, chrom_out1;
    logic        busy, busy1, done, done1, perfect, perfect1;
    logic [3:0]  fitness, fitness1;
    logic [2:0]  unstable_cnt, unstable_cnt1;

    int errors = 0;
    int checks = 0;
    logic busy_hist [0:63];

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    // Circuit stub: output o = chrom_in[select_o[0]]; out0 toggles every cycle in oscillator mode
    assign chrom_out[0]  = osc_mode ? tog : chrom_in[conf_outs[0]];
    assign chrom_out[1]  = chrom_in[conf_outs[3]];
    assign chrom_out1[0] = chrom_in1[conf_outs1[0]];
    assign chrom_out1[1] = chrom_in1[conf_outs1[3]];

    genetico_evaluator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .chrom(chrom), .target(target),
        .conf_les(conf_les), .conf_outs(conf_outs), .chrom_in(chrom_in),
        .chrom_out(chrom_out), .busy(busy), .done(done), .fitness(fitness),
        .perfect(perfect), .unstable_cnt(unstable_cnt)
    );

    genetico_evaluator #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .chrom(chrom), .target(target),
        .conf_les(conf_les1), .conf_outs(conf_outs1), .chrom_in(chrom_in1),
        .chrom_out(chrom_out1), .busy(busy1), .done(done1), .fitness(fitness1),
        .perfect(perfect1), .unstable_cnt(unstable_cnt1)
    );

    // Start accepted at edge 0; cycle i = state after edge i. abort/start pulses are driven
    // after edge k so they are sampled at edge k+1. Returns first done cycle and total done count.
    task automatic run_eval(input bit use1, input int ncyc, input int abort_at,
                            input int sa, input int sb,
                            output int done_cyc, output int done_num);
        done_cyc = -1;
        done_num = 0;
        @(negedge clk);
        if (use1) start1 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start1 = 1'b0;
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk);
            #1;
            busy_hist[i] = use1 ? busy1 : busy;
            if (use1 ? done1 : done) begin
                done_num++;
                if (done_cyc < 0) done_cyc = i;
            end
            abort = (i == abort_at);
            start = (i == sa) || (i == sb);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({conf_les, conf_outs, chrom_in, busy, done, fitness, perfect, unstable_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b fit=%0d conf_outs=%h", busy, done, fitness, conf_outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pass_through;
        int dc, dn;
        chrom = 42'd1 << 39;
        target = 8'hE4;
        run_eval(1'b0, 25, -1, -1, -1, dc, dn);
        checks++;
        if (dc !== 21 || dn !== 1) begin
            errors++; $display("FAIL pass_done_cycle: got cycle=%0d count=%0d, want 21/1", dc, dn);
        end
        checks++;
        if (fitness !== 4'd8 || perfect !== 1'b1 || unstable_cnt !== 3'd0) begin
            errors++; $display("FAIL pass_score: got fit=%0d perf=%b unst=%0d, want 8/1/0", fitness, perfect, unstable_cnt);
        end
        checks++;
        if (conf_outs !== 6'b001_000 || chrom_in !== 2'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL pass_hold: got conf_outs=%b chrom_in=%0d busy=%b", conf_outs, chrom_in, busy);
        end
    endtask

    task automatic test_targets;
        int dc, dn;
        target = 8'h1B;
        run_eval(1'b0, 25, -1, -1, -1, dc, dn);
        checks++;
        if (fitness !== 4'd0 || perfect !== 1'b0 || dn !== 1) begin
            errors++; $display("FAIL target_1b: got fit=%0d perf=%b done=%0d, want 0/0/1", fitness, perfect, dn);
        end
        // 8'hE0 rows v0..v3 = 00,00,10,11 vs outputs 00,01,10,11 -> 2+1+2+2 = 7 matches
        target = 8'hE0;
        run_eval(1'b0, 25, -1, -1, -1, dc, dn);
        checks++;
        if (fitness !== 4'd7 || perfect !== 1'b0) begin
            errors++; $display("FAIL target_e0: got fit=%0d perf=%b, want 7/0", fitness, perfect);
        end
    endtask

    task automatic test_oscillation;
        int dc, dn;
        target = 8'hE4;
        osc_mode = 1'b1;
        run_eval(1'b0, 25, -1, -1, -1, dc, dn);
        osc_mode = 1'b0;
        checks++;
        if (unstable_cnt !== 3'd4 || fitness !== 4'd0 || perfect !== 1'b0 || dc !== 21) begin
            errors++; $display("FAIL oscillation: got unst=%0d fit=%0d perf=%b cyc=%0d, want 4/0/0/21", unstable_cnt, fitness, perfect, dc);
        end
    endtask

    task automatic test_abort;
        int dc, dn;
        run_eval(1'b0, 8, 7, -1, -1, dc, dn);
        run_eval(1'b0, 0, -1, -1, -1, dc, dn);
        // first run: aborted; second call only starts, then idle wait below
        checks++;
        if (busy_hist[7] !== 1'b1 || busy_hist[8] !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got busy7=%b busy8=%b, want 1/0", busy_hist[7], busy_hist[8]);
        end
        // drop the restarted run with an abort, then check nothing changed
        @(negedge clk); abort = 1'b1; @(negedge clk); abort = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++;
        if (dn !== 0 || fitness !== 4'd0 || unstable_cnt !== 3'd4 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_retain: got dones=%0d fit=%0d unst=%0d busy=%b", dn, fitness, unstable_cnt, busy);
        end
        checks++;
        if (conf_outs !== 6'b001_000) begin
            errors++; $display("FAIL abort_conf_kept: got conf_outs=%b want 001000", conf_outs);
        end
        run_eval(1'b0, 25, -1, -1, -1, dc, dn);
        checks++;
        if (dc !== 21 || dn !== 1 || fitness !== 4'd8 || unstable_cnt !== 3'd0) begin
            errors++; $display("FAIL abort_rerun: got cyc=%0d dones=%0d fit=%0d unst=%0d", dc, dn, fitness, unstable_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int dc, dn;
        target = 8'h1B;
        run_eval(1'b0, 30, -1, 2, 11, dc, dn);
        checks++;
        if (dc !== 21 || dn !== 1 || fitness !== 4'd0) begin
            errors++; $display("FAIL start_ignored: got cyc=%0d dones=%0d fit=%0d, want 21/1/0", dc, dn, fitness);
        end
        // mid-run chrom/target changes must not disturb the latched values
        target = 8'hE4;
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        chrom = '0;
        target = 8'h00;
        dn = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chrom = 42'd1 << 39;
        checks++;
        if (dn !== 1 || fitness !== 4'd8 || perfect !== 1'b1) begin
            errors++; $display("FAIL input_latch: got dones=%0d fit=%0d perf=%b, want 1/8/1", dn, fitness, perfect);
        end
    endtask

    task automatic test_async_reset;
        int dc, dn;
        run_eval(1'b0, 10, -1, -1, -1, dc, dn);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({conf_les, conf_outs, chrom_in, busy, done, fitness, perfect, unstable_cnt} !== '0) begin
            errors++; $display("FAIL async_reset: got busy=%b fit=%0d perf=%b conf_outs=%b", busy, fitness, perfect, conf_outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++;
        if (dn !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_no_done: got dones=%0d busy=%b, want 0/0", dn, busy);
        end
    endtask

    task automatic test_settle1;
        int dc, dn;
        target = 8'hE4;
        run_eval(1'b1, 15, -1, -1, -1, dc, dn);
        checks++;
        if (dc !== 9 || dn !== 1 || fitness1 !== 4'd8 || perfect1 !== 1'b1) begin
            errors++; $display("FAIL settle1: got cyc=%0d dones=%0d fit=%0d perf=%b, want 9/1/8/1", dc, dn, fitness1, perfect1);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_targets();
        test_oscillation();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_settle1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got no summary");
        $fatal(1);
    end

endmodule

`default_nettype wire
